top_lvl: RTL and testbench
==========================

Name: top_lvl

Overview:
- Sequential 8-bit unsigned integer divider; computes quotient and remainder of din_N / din_D.
- Radix-2 restoring algorithm: one quotient bit per clock, 8 iterations per division.
- Sits as a standalone arithmetic unit; a controller drives operands and start, then waits for done.
- Results stay registered until the next completed division.

Parameters:
- WIDTH, 8, operand/result bit width. All behaviour and test values below assume WIDTH=8.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- din_N  input  8  dividend (unsigned)
- din_D  input  8  divisor (unsigned)
- start  input  1  request a division; sampled only in IDLE
- dout_Q  output  8  quotient (registered)
- dout_R  output  8  remainder (registered)
- busy  output  1  high while a division is in progress (RUN state)
- done  output  1  single-cycle pulse when new dout_Q/dout_R are valid

Behaviour:
- Reset: one clock; reset asynchronous and active-low. rst_n=0 immediately forces state=IDLE, dout_Q=0, dout_R=0, done=0, busy=0, iteration counter=0, internal working registers=0. Reset mid-division aborts the division with no result update.
- FSM states: IDLE, RUN, DONE.
- IDLE: done=0, busy=0. On a rising edge with start=1:
  - If din_D != 0: latch N and D into internal registers, clear partial remainder (9-bit) and counter, go to RUN.
  - If din_D == 0: go directly to DONE with dout_Q=8'hFF and dout_R=din_N.
- RUN: busy=1. Each rising edge performs one restoring step, MSB first:
  - Shift {rem, N} left by 1.
  - Trial = rem - D (9-bit).
  - If trial is non-negative: rem=trial and quotient bit=1; otherwise rem unchanged and quotient bit=0.
  - Counter increments.
- End of RUN: on the 8th RUN edge, write final quotient to dout_Q and remainder (low 8 bits) to dout_R, then go to DONE.
- DONE: done=1, busy=0 for exactly one cycle, then unconditionally IDLE. start is ignored in DONE.
- Latency: for din_D != 0, done is high in the cycle following the 9th rising edge, counting the start-sampling edge as edge 1. For din_D = 0, done is high after edge 1.
- start asserted during RUN or DONE is ignored. No queuing.
- Operands are captured at the start edge. Changes to din_N/din_D during RUN do not affect the result.
- dout_Q/dout_R change only on the edge that enters DONE (or on reset); otherwise they hold.
- Invariant for D != 0: N = Q*D + R, with R < D.
- Continuous start=1 yields back-to-back divisions: each begins on the first IDLE edge after DONE.

Test Plan:
- Reset, then din_N=10, din_D=2, start pulse -> busy high for 8 cycles; then done=1 for one cycle with dout_Q=5, dout_R=0.
- din_N=255, din_D=16 -> dout_Q=15, dout_R=15. Also din_N=7, din_D=9 -> dout_Q=0, dout_R=7. Also din_N=200, din_D=1 -> dout_Q=200, dout_R=0.
- din_N=100, din_D=0, start -> done after one edge with dout_Q=255, dout_R=100; busy never asserted.
- Start 10/2, change din_N to 99 and pulse start during RUN -> result remains Q=5, R=0; only one done pulse.
- Start 200/7, drop rst_n mid-RUN -> outputs 0, busy=0, done never asserted. Release rst_n and start 200/7 -> Q=28, R=4.
- Randomised sweep of all N, D with D != 0 against a reference model: Q = N/D, R = N%D; verify the done latency of 9 edges each time.

Source files
------------

// File: rtl/top_lvl.sv
// Sequential radix-2 restoring divider: one quotient bit per clock.
// Quotient and remainder stay registered until the next completed division.
module top_lvl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din_N,
    input  logic [WIDTH-1:0] din_D,
    input  logic             start,
    output logic [WIDTH-1:0] dout_Q,
    output logic [WIDTH-1:0] dout_R,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] n_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   shifted;
    logic             qbit;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic             last;

    // The stored remainder is always < D, so WIDTH bits hold it; only the
    // shifted trial value needs the extra bit for the restoring compare.
    always_comb begin
        shifted  = {rem, n_reg[WIDTH-1]};
        qbit     = (shifted >= {1'b0, d_reg});
        rem_next = qbit ? (shifted[WIDTH-1:0] - d_reg) : shifted[WIDTH-1:0];
        quo_next = {n_reg[WIDTH-2:0], qbit};
        last     = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (din_D == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_reg  <= '0;
            d_reg  <= '0;
            rem    <= '0;
            cnt    <= '0;
            dout_Q <= '0;
            dout_R <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (din_D != '0) begin
                            n_reg <= din_N;
                            d_reg <= din_D;
                            rem   <= '0;
                            cnt   <= '0;
                        end else begin
                            dout_Q <= '1;
                            dout_R <= din_N;
                        end
                    end
                end
                RUN: begin
                    // n_reg doubles as the quotient: dividend bits shift out, quotient bits in
                    n_reg <= quo_next;
                    rem   <= rem_next;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        dout_Q <= quo_next;
                        dout_R <= rem_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_top_lvl.sv
// Directed self-checking bench for the sequential divider top_lvl.
module tb_top_lvl;

    logic       clk;
    logic       rst_n;
    logic [7:0] din_N;
    logic [7:0] din_D;
    logic       start;
    logic [7:0] dout_Q;
    logic [7:0] dout_R;
    logic       busy;
    logic       done;

    int n_assert;
    int n_fail;

    top_lvl #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .din_N  (din_N),
        .din_D  (din_D),
        .start  (start),
        .dout_Q (dout_Q),
        .dout_R (dout_R),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One division: start pulse for a single edge, then wait (bounded) for done.
    task automatic run_div(input string tag, input logic [7:0] n, input logic [7:0] d,
                           input logic [7:0] exp_q, input logic [7:0] exp_r, input int exp_lat);
        int edges;
        int busy_cnt;
        @(negedge clk);
        din_N = n;
        din_D = d;
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        edges    = 1;
        busy_cnt = busy ? 1 : 0;
        while (!done && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
            if (busy) busy_cnt++;
        end
        check({tag, "_latency"}, edges, exp_lat);
        check({tag, "_busy_cycles"}, busy_cnt, (d != 0) ? 8 : 0);
        check({tag, "_q"}, dout_Q, exp_q);
        check({tag, "_r"}, dout_R, exp_r);
        @(posedge clk);
        #1;
        check({tag, "_done_single"}, done, 1'b0);
    endtask

    initial begin
        int edges;
        int pulses;
        int gap;
        logic [7:0] cap_q;
        logic [7:0] cap_r;
        logic [7:0] rn;
        logic [7:0] rd;

        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        din_N    = '0;
        din_D    = '0;

        // Reset state
        #12;
        check("rst_q", dout_Q, 8'd0);
        check("rst_r", dout_R, 8'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed divisions
        run_div("d10_2", 8'd10, 8'd2, 8'd5, 8'd0, 9);
        run_div("d255_16", 8'd255, 8'd16, 8'd15, 8'd15, 9);
        run_div("d7_9", 8'd7, 8'd9, 8'd0, 8'd7, 9);
        run_div("d200_1", 8'd200, 8'd1, 8'd200, 8'd0, 9);
        run_div("d255_255", 8'd255, 8'd255, 8'd1, 8'd0, 9);
        run_div("d0_5", 8'd0, 8'd5, 8'd0, 8'd0, 9);
        run_div("d1_255", 8'd1, 8'd255, 8'd0, 8'd1, 9);
        run_div("d254_127", 8'd254, 8'd127, 8'd2, 8'd0, 9);

        // Divide by zero
        run_div("d100_0", 8'd100, 8'd0, 8'd255, 8'd100, 1);

        // Results hold while idle
        repeat (3) @(posedge clk);
        #1;
        check("hold_q", dout_Q, 8'd255);
        check("hold_r", dout_R, 8'd100);

        // Operand change and start during RUN are ignored
        @(negedge clk);
        din_N = 8'd10;
        din_D = 8'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        din_N = 8'd99;
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        cap_q  = '0;
        cap_r  = '0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                pulses++;
                cap_q = dout_Q;
                cap_r = dout_R;
            end
        end
        check("midrun_pulses", pulses, 1);
        check("midrun_q", cap_q, 8'd5);
        check("midrun_r", cap_r, 8'd0);

        // Reset mid-division
        @(negedge clk);
        din_N = 8'd200;
        din_D = 8'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_q", dout_Q, 8'd0);
        check("midrst_r", dout_R, 8'd0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("midrst_no_done", pulses, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("midrst_no_done_after", pulses, 0);
        run_div("d200_7", 8'd200, 8'd7, 8'd28, 8'd4, 9);

        // Continuous start: back-to-back divisions, done pulses 10 edges apart
        @(negedge clk);
        din_N = 8'd12;
        din_D = 8'd5;
        start = 1'b1;
        edges = 0;
        gap   = 0;
        pulses = 0;
        while (pulses < 2 && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
            if (pulses == 1) gap++;
            if (done) begin
                pulses++;
                check("b2b_q", dout_Q, 8'd2);
                check("b2b_r", dout_R, 8'd2);
            end
        end
        check("b2b_pulses", pulses, 2);
        check("b2b_gap", gap, 10);
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(posedge clk);

        // Random sweep against a reference model
        for (int i = 0; i < 200; i++) begin
            rn = 8'($urandom_range(255, 0));
            rd = 8'($urandom_range(255, 1));
            run_div("rand", rn, rd, rn / rd, rn % rd, 9);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
